// File: rtl/bp_cfg_boot_sequencer_if.sv
// Boot ROM read port and config write link between the boot sequencer and its neighbours.
// The master side is the sequencer; the slave side is the ROM plus the config endpoints.
interface bp_cfg_boot_sequencer_if #(
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int num_entries_p    = 16
);
    localparam int lg_entries_lp  = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
    localparam int entry_width_lp = 1 + cfg_addr_width_p + cfg_data_width_p;

    logic                        rom_v;
    logic [lg_entries_lp-1:0]    rom_addr;
    logic [entry_width_lp-1:0]   rom_data;

    logic                        cfg_v;
    logic [cfg_core_width_p-1:0] cfg_core;
    logic [cfg_addr_width_p-1:0] cfg_addr;
    logic [cfg_data_width_p-1:0] cfg_data;
    logic                        cfg_ready;

    modport master (
        output rom_v, rom_addr,
        input  rom_data,
        output cfg_v, cfg_core, cfg_addr, cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  rom_v, rom_addr,
        output rom_data,
        input  cfg_v, cfg_core, cfg_addr, cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: walks a {last, addr, data} script held in a synchronous ROM and
// broadcasts each entry as one config write per core, then holds done until restarted.
module bp_cfg_boot_sequencer #(
    parameter int num_core_p       = 1,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int num_entries_p    = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    bp_cfg_boot_sequencer_if.master       bus,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int lg_entries_lp  = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
    localparam int entry_width_lp = 1 + cfg_addr_width_p + cfg_data_width_p;
    localparam int core_w_lp      = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    if (num_core_p > (1 << cfg_core_width_p)) begin : g_core_width_chk
        $error("num_core_p does not fit in cfg_core_width_p bits");
    end

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, SEND, DONE} state_e;

    state_e                      state_r, state_n;
    logic [lg_entries_lp-1:0]    entry_r;
    logic [core_w_lp-1:0]        core_r;
    logic                        last_r;
    logic [cfg_addr_width_p-1:0] addr_r;
    logic [cfg_data_width_p-1:0] data_r;

    logic xfer, core_last, script_end;

    assign xfer       = (state_r == SEND) && bus.cfg_ready;
    assign core_last  = (core_r == core_w_lp'(num_core_p - 1));
    // Final table slot ends the script even without a last bit, so entry_r never wraps.
    assign script_end = last_r || (entry_r == lg_entries_lp'(num_entries_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:     if (start_i) state_n = FETCH;
            FETCH:    state_n = WAIT_ROM;
            WAIT_ROM: state_n = SEND;
            SEND:     if (xfer && core_last) state_n = script_end ? DONE : FETCH;
            DONE:     if (start_i) state_n = FETCH;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            entry_r <= '0;
            core_r  <= '0;
            last_r  <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: if (start_i) entry_r <= '0;
                WAIT_ROM: begin
                    last_r <= bus.rom_data[entry_width_lp-1];
                    addr_r <= bus.rom_data[entry_width_lp-2 -: cfg_addr_width_p];
                    data_r <= bus.rom_data[cfg_data_width_p-1:0];
                    core_r <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        if (!core_last)       core_r  <= core_r + 1'b1;
                        else if (!script_end) entry_r <= entry_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid and payload come only from registers, never from cfg_ready.
    always_comb begin
        bus.rom_v    = (state_r == FETCH);
        bus.rom_addr = entry_r;
        bus.cfg_v    = (state_r == SEND);
        bus.cfg_core = cfg_core_width_p'(core_r);
        bus.cfg_addr = addr_r;
        bus.cfg_data = data_r;
        busy_o       = (state_r == FETCH) || (state_r == WAIT_ROM) || (state_r == SEND);
        done_o       = (state_r == DONE);
    end
endmodule
